add_rs_bank: RTL and testbench

Reservation-station bank for the three adder-class functional units (add1..add3), directly downstream of the order manager. It accepts renamed issue packets: entry select, source values or producer ROB tags, and destination ROB tag. It snoops the common data bus (CDB) to resolve pending operands and dispatches ready entries to the adder pipe through a valid/ready output register. Per-entry busy bits feed back to the order manager's structural-hazard check.

---
 rtl/add_rs_if.sv | 42 ++++
 rtl/add_rs_bank.sv | 159 +++++++++++++++
 tb/tb_add_rs_bank.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_rs_if.sv
// Issue, CDB snoop and dispatch signals of the adder reservation-station bank.
interface add_rs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 3
);
  logic              flush;
  logic              issue_valid;
  logic [1:0]        issue_sel;
  logic [1:0]        issue_op;
  logic [DATA_W-1:0] issue_vj;
  logic [DATA_W-1:0] issue_vk;
  logic              issue_qj_busy;
  logic              issue_qk_busy;
  logic [TAG_W-1:0]  issue_qj;
  logic [TAG_W-1:0]  issue_qk;
  logic [TAG_W-1:0]  issue_dest;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [2:0]        busy;
  logic              issue_err;
  logic              ex_valid;
  logic              ex_ready;
  logic [1:0]        ex_op;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [TAG_W-1:0]  ex_dest;

  modport master (
    output flush, issue_valid, issue_sel, issue_op, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_dest,
           cdb_valid, cdb_tag, cdb_data, ex_ready,
    input  busy, issue_err, ex_valid, ex_op, ex_a, ex_b, ex_dest
  );

  modport slave (
    input  flush, issue_valid, issue_sel, issue_op, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_dest,
           cdb_valid, cdb_tag, cdb_data, ex_ready,
    output busy, issue_err, ex_valid, ex_op, ex_a, ex_b, ex_dest
  );
endinterface

// File: rtl/add_rs_bank.sv
// Three-entry reservation station for the adder units: issue, CDB wakeup,
// lowest-index dispatch into a valid/ready output register.
module add_rs_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 3
) (
  input  logic   clk,
  input  logic   rst,
  add_rs_if.slave bus
);
  localparam int unsigned NUM_ENT = 3;

  typedef struct packed {
    logic              busy;
    logic [1:0]        op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic              qj_busy;
    logic [TAG_W-1:0]  qj;
    logic              qk_busy;
    logic [TAG_W-1:0]  qk;
    logic [TAG_W-1:0]  dest;
  } entry_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  dest;
  } ex_t;

  entry_t               ent_q [NUM_ENT];
  entry_t               ent_d [NUM_ENT];
  entry_t               new_ent;
  ex_t                  ex_q;
  ex_t                  ex_d;
  logic                 ex_valid_q;
  logic                 ex_valid_d;
  logic                 issue_err_q;
  logic                 issue_err_d;
  logic [NUM_ENT-1:0]   busy_vec;
  logic [NUM_ENT-1:0]   ready;
  logic [NUM_ENT-1:0]   grant;
  logic [NUM_ENT-1:0]   issue_hit;
  logic                 found;
  logic                 out_free;
  logic                 fwd_j;
  logic                 fwd_k;

  // Readiness, lowest-index grant and issue target decode.
  always_comb begin
    busy_vec  = '0;
    ready     = '0;
    grant     = '0;
    issue_hit = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_ENT; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready[i]     = ent_q[i].busy & ~ent_q[i].qj_busy & ~ent_q[i].qk_busy;
      issue_hit[i] = (bus.issue_sel == 2'(i));
      if (ready[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign out_free = !ex_valid_q || bus.ex_ready;

  // Incoming packet, with operands captured straight off the CDB on a tag match.
  always_comb begin
    fwd_j = bus.issue_qj_busy && bus.cdb_valid && (bus.cdb_tag == bus.issue_qj);
    fwd_k = bus.issue_qk_busy && bus.cdb_valid && (bus.cdb_tag == bus.issue_qk);
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.op      = bus.issue_op;
    new_ent.vj      = fwd_j ? bus.cdb_data : bus.issue_vj;
    new_ent.vk      = fwd_k ? bus.cdb_data : bus.issue_vk;
    new_ent.qj_busy = bus.issue_qj_busy && !fwd_j;
    new_ent.qk_busy = bus.issue_qk_busy && !fwd_k;
    new_ent.qj      = bus.issue_qj;
    new_ent.qk      = bus.issue_qk;
    new_ent.dest    = bus.issue_dest;
  end

  // Entry next state: wakeup, dispatch release, issue write, flush (highest priority last).
  always_comb begin
    issue_err_d = bus.issue_valid &&
                  ((issue_hit == '0) || ((issue_hit & busy_vec) != '0));
    for (int i = 0; i < NUM_ENT; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && bus.cdb_valid) begin
        if (ent_q[i].qj_busy && (ent_q[i].qj == bus.cdb_tag)) begin
          ent_d[i].vj      = bus.cdb_data;
          ent_d[i].qj_busy = 1'b0;
        end
        if (ent_q[i].qk_busy && (ent_q[i].qk == bus.cdb_tag)) begin
          ent_d[i].vk      = bus.cdb_data;
          ent_d[i].qk_busy = 1'b0;
        end
      end
      if (out_free && grant[i]) begin
        ent_d[i].busy = 1'b0;
      end
      if (bus.issue_valid && issue_hit[i] && !ent_q[i].busy) begin
        ent_d[i] = new_ent;
      end
      if (bus.flush) begin
        ent_d[i].busy = 1'b0;
      end
    end
  end

  // Output register: load on free slot, hold while stalled.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (out_free) begin
      ex_valid_d = |ready;
      for (int i = 0; i < NUM_ENT; i++) begin
        if (grant[i]) begin
          ex_d.op   = ent_q[i].op;
          ex_d.a    = ent_q[i].vj;
          ex_d.b    = ent_q[i].vk;
          ex_d.dest = ent_q[i].dest;
        end
      end
    end
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        ent_q[i] <= '0;
      end
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      issue_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        ent_q[i] <= ent_d[i];
      end
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      issue_err_q <= issue_err_d;
    end
  end

  assign bus.busy      = busy_vec;
  assign bus.issue_err = issue_err_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_op     = ex_q.op;
  assign bus.ex_a      = ex_q.a;
  assign bus.ex_b      = ex_q.b;
  assign bus.ex_dest   = ex_q.dest;
endmodule

// File: tb/tb_add_rs_bank.sv
// Directed bench for add_rs_bank: issue, wakeup, forwarding, stall, errors, flush, reset.
module tb_add_rs_bank;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  add_rs_if #(.DATA_W(32), .TAG_W(3)) bus ();

  add_rs_bank #(.DATA_W(32), .TAG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_issue();
    bus.issue_valid   = 1'b0;
    bus.issue_sel     = 2'd0;
    bus.issue_op      = 2'd0;
    bus.issue_vj      = 32'd0;
    bus.issue_vk      = 32'd0;
    bus.issue_qj_busy = 1'b0;
    bus.issue_qk_busy = 1'b0;
    bus.issue_qj      = 3'd0;
    bus.issue_qk      = 3'd0;
    bus.issue_dest    = 3'd0;
  endtask

  task automatic clear_cdb();
    bus.cdb_valid = 1'b0;
    bus.cdb_tag   = 3'd0;
    bus.cdb_data  = 32'd0;
  endtask

  task automatic drive_cdb(input logic [2:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  task automatic drive_issue(input logic [1:0] sel, input logic [1:0] op,
                             input logic [31:0] vj, input logic [31:0] vk,
                             input logic qjb, input logic [2:0] qj,
                             input logic qkb, input logic [2:0] qk,
                             input logic [2:0] dest);
    bus.issue_valid   = 1'b1;
    bus.issue_sel     = sel;
    bus.issue_op      = op;
    bus.issue_vj      = vj;
    bus.issue_vk      = vk;
    bus.issue_qj_busy = qjb;
    bus.issue_qj      = qj;
    bus.issue_qk_busy = qkb;
    bus.issue_qk      = qk;
    bus.issue_dest    = dest;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b0;
    clear_issue();
    clear_cdb();
    repeat (2) tick();
    checks++; if (bus.busy !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", bus.busy); end
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b exp=0", bus.ex_valid); end
    checks++; if (bus.issue_err !== 1'b0) begin failures++; $display("FAIL reset_issue_err got=%b exp=0", bus.issue_err); end
    checks++; if ({bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_dest} !== '0) begin failures++; $display("FAIL reset_ex_payload got=%h/%h/%h/%h exp=0", bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_dest); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ready_issue();
    bus.ex_ready = 1'b1;
    drive_issue(2'd1, 2'd0, 32'd5, 32'd7, 1'b0, 3'd0, 1'b0, 3'd0, 3'd2);
    tick();
    clear_issue();
    checks++; if (bus.busy !== 3'b010) begin failures++; $display("FAIL ready_busy_e1 got=%b exp=010", bus.busy); end
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL ready_valid_e1 got=%b exp=0", bus.ex_valid); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL ready_valid_e2 got=%b exp=1", bus.ex_valid); end
    checks++; if (bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7) begin failures++; $display("FAIL ready_operands got=%0d,%0d exp=5,7", bus.ex_a, bus.ex_b); end
    checks++; if (bus.ex_dest !== 3'd2 || bus.ex_op !== 2'd0) begin failures++; $display("FAIL ready_dest_op got=%0d,%0d exp=2,0", bus.ex_dest, bus.ex_op); end
    checks++; if (bus.busy !== 3'b000) begin failures++; $display("FAIL ready_busy_e2 got=%b exp=000", bus.busy); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL ready_drain got=%b exp=0", bus.ex_valid); end
  endtask

  task automatic test_cdb_wakeup();
    bus.ex_ready = 1'b1;
    drive_issue(2'd0, 2'd1, 32'd0, 32'd10, 1'b1, 3'd4, 1'b0, 3'd0, 3'd5);
    tick();
    clear_issue();
    checks++; if (bus.busy !== 3'b001) begin failures++; $display("FAIL wake_busy_issue got=%b exp=001", bus.busy); end
    drive_cdb(3'd3, 32'hdead);
    tick();
    clear_cdb();
    tick();
    checks++; if (bus.ex_valid !== 1'b0 || bus.busy !== 3'b001) begin failures++; $display("FAIL wake_wrong_tag got=%b/%b exp=0/001", bus.ex_valid, bus.busy); end
    drive_cdb(3'd4, 32'h1234);
    tick();
    clear_cdb();
    checks++; if (bus.ex_valid !== 1'b0 || bus.busy !== 3'b001) begin failures++; $display("FAIL wake_cdb_edge got=%b/%b exp=0/001", bus.ex_valid, bus.busy); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'h1234) begin failures++; $display("FAIL wake_dispatch got=%b/%h exp=1/1234", bus.ex_valid, bus.ex_a); end
    checks++; if (bus.ex_b !== 32'd10 || bus.ex_op !== 2'd1 || bus.ex_dest !== 3'd5) begin failures++; $display("FAIL wake_payload got=%0d/%0d/%0d exp=10/1/5", bus.ex_b, bus.ex_op, bus.ex_dest); end
    checks++; if (bus.busy !== 3'b000) begin failures++; $display("FAIL wake_busy_clear got=%b exp=000", bus.busy); end
    tick();
  endtask

  task automatic test_dual_wake_tag0();
    bus.ex_ready = 1'b1;
    drive_issue(2'd2, 2'd3, 32'd0, 32'd0, 1'b1, 3'd0, 1'b1, 3'd0, 3'd0);
    tick();
    clear_issue();
    drive_cdb(3'd0, 32'h77);
    tick();
    clear_cdb();
    checks++; if (bus.ex_valid !== 1'b0 || bus.busy !== 3'b100) begin failures++; $display("FAIL dual_wake_edge got=%b/%b exp=0/100", bus.ex_valid, bus.busy); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'h77 || bus.ex_b !== 32'h77) begin failures++; $display("FAIL dual_wake_operands got=%b/%h/%h exp=1/77/77", bus.ex_valid, bus.ex_a, bus.ex_b); end
    checks++; if (bus.ex_op !== 2'd3 || bus.ex_dest !== 3'd0) begin failures++; $display("FAIL dual_wake_op_dest got=%0d/%0d exp=3/0", bus.ex_op, bus.ex_dest); end
    tick();
  endtask

  task automatic test_hold();
    bus.ex_ready = 1'b0;
    drive_issue(2'd0, 2'd0, 32'd0, 32'd2, 1'b1, 3'd7, 1'b0, 3'd0, 3'd1);
    tick();
    drive_issue(2'd2, 2'd0, 32'd0, 32'd3, 1'b1, 3'd7, 1'b0, 3'd0, 3'd3);
    tick();
    clear_issue();
    drive_cdb(3'd7, 32'h10);
    tick();
    clear_cdb();
    checks++; if (bus.busy !== 3'b101 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL hold_both_ready got=%b/%b exp=101/0", bus.busy, bus.ex_valid); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 3'd1 || bus.busy !== 3'b100) begin failures++; $display("FAIL hold_first got=%b/%0d/%b exp=1/1/100", bus.ex_valid, bus.ex_dest, bus.busy); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 3'd1 || bus.ex_a !== 32'h10 || bus.ex_b !== 32'd2 || bus.busy !== 3'b100) begin
        failures++; $display("FAIL hold_stall_%0d got=%b/%0d/%h/%0d/%b exp=1/1/10/2/100", c, bus.ex_valid, bus.ex_dest, bus.ex_a, bus.ex_b, bus.busy);
      end
    end
    bus.ex_ready = 1'b1;
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 3'd3 || bus.ex_b !== 32'd3 || bus.busy !== 3'b000) begin failures++; $display("FAIL hold_second got=%b/%0d/%0d/%b exp=1/3/3/000", bus.ex_valid, bus.ex_dest, bus.ex_b, bus.busy); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL hold_drain got=%b exp=0", bus.ex_valid); end
  endtask

  task automatic test_same_cycle_fwd();
    bus.ex_ready = 1'b1;
    drive_issue(2'd1, 2'd2, 32'hff, 32'd0, 1'b0, 3'd0, 1'b1, 3'd6, 3'd6);
    drive_cdb(3'd6, 32'd9);
    tick();
    clear_issue();
    clear_cdb();
    checks++; if (bus.busy !== 3'b010 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL fwd_e1 got=%b/%b exp=010/0", bus.busy, bus.ex_valid); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_b !== 32'd9 || bus.ex_a !== 32'hff || bus.ex_op !== 2'd2) begin failures++; $display("FAIL fwd_e2 got=%b/%0d/%h/%0d exp=1/9/ff/2", bus.ex_valid, bus.ex_b, bus.ex_a, bus.ex_op); end
    tick();
  endtask

  task automatic test_issue_err();
    bus.ex_ready = 1'b1;
    drive_issue(2'd1, 2'd0, 32'd0, 32'h20, 1'b1, 3'd1, 1'b0, 3'd0, 3'd4);
    tick();
    checks++; if (bus.busy !== 3'b010 || bus.issue_err !== 1'b0) begin failures++; $display("FAIL err_first_issue got=%b/%b exp=010/0", bus.busy, bus.issue_err); end
    drive_issue(2'd1, 2'd1, 32'h55, 32'h66, 1'b0, 3'd0, 1'b0, 3'd0, 3'd7);
    tick();
    clear_issue();
    checks++; if (bus.issue_err !== 1'b1 || bus.busy !== 3'b010) begin failures++; $display("FAIL err_busy_pulse got=%b/%b exp=1/010", bus.issue_err, bus.busy); end
    tick();
    checks++; if (bus.issue_err !== 1'b0 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL err_busy_drop got=%b/%b exp=0/0", bus.issue_err, bus.ex_valid); end
    drive_cdb(3'd1, 32'ha);
    tick();
    clear_cdb();
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'ha || bus.ex_b !== 32'h20 || bus.ex_dest !== 3'd4 || bus.ex_op !== 2'd0) begin
      failures++; $display("FAIL err_contents got=%b/%h/%h/%0d/%0d exp=1/a/20/4/0", bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_dest, bus.ex_op);
    end
    drive_issue(2'd3, 2'd0, 32'd1, 32'd1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd1);
    tick();
    clear_issue();
    checks++; if (bus.issue_err !== 1'b1 || bus.busy !== 3'b000) begin failures++; $display("FAIL err_sel3_pulse got=%b/%b exp=1/000", bus.issue_err, bus.busy); end
    tick();
    checks++; if (bus.issue_err !== 1'b0 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL err_sel3_drop got=%b/%b exp=0/0", bus.issue_err, bus.ex_valid); end
  endtask

  task automatic test_back_to_back();
    bus.ex_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive_issue(2'(k % 3), 2'd0, 32'(k * 10), 32'd1, 1'b0, 3'd0, 1'b0, 3'd0, 3'(k + 1));
      else clear_issue();
      tick();
      checks++; if (bus.issue_err !== 1'b0) begin failures++; $display("FAIL b2b_err_%0d got=%b exp=0", k, bus.issue_err); end
      if (k >= 1 && k <= 4) begin
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 3'(k) || bus.ex_a !== 32'((k - 1) * 10)) begin
          failures++; $display("FAIL b2b_dispatch_%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, bus.ex_valid, bus.ex_dest, bus.ex_a, k, (k - 1) * 10);
        end
      end else begin
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_%0d got=%b exp=0", k, bus.ex_valid); end
      end
    end
  endtask

  task automatic test_flush();
    bus.ex_ready = 1'b0;
    drive_issue(2'd0, 2'd0, 32'd1, 32'd1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd1);
    tick();
    drive_issue(2'd1, 2'd0, 32'd0, 32'd0, 1'b1, 3'd2, 1'b0, 3'd0, 3'd2);
    tick();
    drive_issue(2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 3'd3, 1'b0, 3'd0, 3'd3);
    tick();
    drive_issue(2'd2, 2'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd5, 3'd5);
    tick();
    clear_issue();
    checks++; if (bus.busy !== 3'b111 || bus.ex_valid !== 1'b1 || bus.ex_dest !== 3'd1) begin failures++; $display("FAIL flush_pre got=%b/%b/%0d exp=111/1/1", bus.busy, bus.ex_valid, bus.ex_dest); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 3'b000 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL flush_edge got=%b/%b exp=000/0", bus.busy, bus.ex_valid); end
    bus.ex_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) drive_cdb(3'd2, 32'h2);
      else if (t == 1) drive_cdb(3'd3, 32'h3);
      else if (t == 2) drive_cdb(3'd5, 32'h5);
      else clear_cdb();
      tick();
      checks++; if (bus.busy !== 3'b000 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL flush_stale_cdb_%0d got=%b/%b exp=000/0", t, bus.busy, bus.ex_valid); end
    end
    clear_cdb();
  endtask

  task automatic test_async_reset();
    bus.ex_ready = 1'b0;
    drive_issue(2'd0, 2'd1, 32'h11, 32'h22, 1'b0, 3'd0, 1'b0, 3'd0, 3'd6);
    tick();
    drive_issue(2'd1, 2'd0, 32'd0, 32'd0, 1'b1, 3'd1, 1'b0, 3'd0, 3'd2);
    tick();
    drive_issue(2'd1, 2'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd3);
    tick();
    clear_issue();
    checks++; if (bus.ex_valid !== 1'b1 || bus.issue_err !== 1'b1 || bus.busy !== 3'b010 || bus.ex_a !== 32'h11) begin
      failures++; $display("FAIL arst_pre got=%b/%b/%b/%h exp=1/1/010/11", bus.ex_valid, bus.issue_err, bus.busy, bus.ex_a);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 3'b000 || bus.ex_valid !== 1'b0 || bus.issue_err !== 1'b0) begin failures++; $display("FAIL arst_ctrl got=%b/%b/%b exp=000/0/0", bus.busy, bus.ex_valid, bus.issue_err); end
    checks++; if ({bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_dest} !== '0) begin failures++; $display("FAIL arst_payload got=%h/%h/%h/%h exp=0", bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_dest); end
    #2;
    rst = 1'b0;
    tick();
    checks++; if (bus.busy !== 3'b000 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL arst_after got=%b/%b exp=000/0", bus.busy, bus.ex_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ready_issue();
    test_cdb_wakeup();
    test_dual_wake_tag0();
    test_hold();
    test_same_cycle_fwd();
    test_issue_err();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
